pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage core.
- Decides each cycle which pipeline registers hold (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and when all stages flush.
- Sequences multi-cycle EX operations (madd/msub/div) by holding the front of the pipe for a programmed number of cycles.
- Supplies the redirect PC on exceptions and eret.
- Sits beside the stage registers; each stage register consumes `stall` and `flush`.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_mc_seq.sv | 102 ++++++++++
 rtl/pipe_ctrl.sv | 87 ++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared constants and types for the pipeline controller.
//            - Per-stage hold vectors. The bit order is PC, IF, ID, EX, MEM, WB.
//            - MEM-stage exception codes, including the eret code.
//            - The default exception handler address.
//            - The multi-cycle sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Hold vectors. A stage whose bit is set keeps its register contents.
    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_FROM_ID = 6'b000111; // PC, IF, ID hold
    localparam logic [5:0] STALL_FROM_EX = 6'b001111; // PC, IF, ID, EX hold

    // Exception codes as reported by the MEM stage.
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Every exception except eret is vectored to this address.
    localparam logic [31:0] EXC_HANDLER_DEFAULT = 32'h0000_0020;

    // Multi-cycle sequencer states.
    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_mc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_mc_seq
// Purpose  : Sequencer for multi-cycle EX operations (madd/msub/div).
//            It holds the front of the pipe for a programmed number of cycles,
//            then pulses done for one cycle.
//            A start at cycle t with length N holds cycles t..t+N-1.
//            The done pulse comes in cycle t+N. A length of 0 is run as 1.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            start       - launch a sequence (accepted in MC_IDLE only)
//            cycles      - sequence length, sampled with start
//            abort       - drop the sequence immediately (exception flush)
//            hold        - front-of-pipe hold request, same cycle
//            done        - one-cycle result-valid pulse
//            busy        - sequence in progress (state == MC_BUSY)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_mc_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             abort,
    output logic             hold,
    output logic             done,
    output logic             busy
);

    mc_state_t        state;
    mc_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        done      = 1'b0;

        unique case (state)
            MC_IDLE: begin
                if (start) begin
                    hold      = 1'b1;
                    // The start cycle itself is the first hold cycle, so we
                    // load N-1. A length of 0 loads 0, which runs it as 1.
                    cnt_nxt   = (cycles == '0) ? '0 : cycles - CNT_W'(1);
                    state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (cnt != '0) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    done      = 1'b1;
                    state_nxt = MC_IDLE;
                end
            end
            default: begin
                state_nxt = MC_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // An exception, or reset, kills the sequence. It produces no result
        // pulse and no hold.
        if (abort || rst) begin
            state_nxt = MC_IDLE;
            cnt_nxt   = '0;
            hold      = 1'b0;
            done      = 1'b0;
        end
    end

    // The state register still shows MC_BUSY during the first reset cycle.
    // Gate busy so that it reads 0 for as long as rst is high.
    assign busy = (state == MC_BUSY) && !rst;

`ifndef SYNTHESIS
    // Launching a new op while one is in flight is a protocol error. The
    // request is dropped in hardware.
    a_no_start_when_busy : assert property (
        @(posedge clk) disable iff (rst) !(start && state == MC_BUSY)
    ) else $error("pipe_ctrl_mc_seq: start while busy");
`endif

endmodule : pipe_ctrl_mc_seq
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central controller for the five-stage pipeline.
//            It decides per cycle which stage registers hold and when all
//            stages flush. It also sequences multi-cycle EX ops and supplies
//            the redirect PC for exceptions and eret.
//            Priority, highest first:
//              exception flush > multi-cycle hold > EX request > ID request.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            stallreq_id  - load-use hazard in ID
//            stallreq_ex  - single-cycle EX hold
//            mc_start     - EX launches a multi-cycle op
//            mc_cycles    - op length, sampled with mc_start
//            exc_valid    - MEM reports an exception or eret
//            exc_type     - MEM exception code
//            cp0_epc      - EPC, the return target for eret
//            stall        - per-stage hold {WB,MEM,EX,ID,IF,PC}
//            flush        - clear every stage register
//            new_pc       - redirect target, valid with flush
//            mc_busy      - multi-cycle sequence in progress
//            mc_done      - multi-cycle result valid pulse
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 6,
    parameter logic [31:0] EXC_HANDLER = EXC_HANDLER_DEFAULT,
    parameter logic [31:0] ERET_CODE   = EXC_ERET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             exc_valid,
    input  logic [31:0]      exc_type,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_busy,
    output logic             mc_done
);

    logic mc_hold;

    pipe_ctrl_mc_seq #(
        .CNT_W (CNT_W)
    ) u_mc_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (mc_start),
        .cycles (mc_cycles),
        .abort  (exc_valid),
        .hold   (mc_hold),
        .done   (mc_done),
        .busy   (mc_busy)
    );

    // Priority mux. Everything here is combinational so that it acts in the
    // same cycle as the request.
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'h0;

        if (rst) begin
            stall  = STALL_NONE;
        end else if (exc_valid) begin
            // A flush empties the pipe, so holding a stage would be
            // meaningless. The redirect target overrides the PC directly.
            flush  = 1'b1;
            new_pc = (exc_type == ERET_CODE) ? cp0_epc : EXC_HANDLER;
        end else if (mc_hold || stallreq_ex) begin
            // The EX hold is a superset of the ID hold. An ID request raised
            // during a multi-cycle op therefore needs no separate handling.
            stall  = STALL_FROM_EX;
        end else if (stallreq_id) begin
            stall  = STALL_FROM_ID;
        end
    end

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. Expected outputs come from a
//            time-based reference model. They are queued as each cycle is
//            driven, and compared against the DUT mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             mc_start;
    logic [CNT_W-1:0] mc_cycles;
    logic             exc_valid;
    logic [31:0]      exc_type;
    logic [31:0]      cp0_epc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             mc_busy;
    logic             mc_done;

    pipe_ctrl #(
        .CNT_W       (CNT_W),
        .EXC_HANDLER (32'h0000_0020),
        .ERET_CODE   (32'h0000_000e)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .mc_start    (mc_start),
        .mc_cycles   (mc_cycles),
        .exc_valid   (exc_valid),
        .exc_type    (exc_type),
        .cp0_epc     (cp0_epc),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Reference model state. The model tracks the number of cycles elapsed
    // since the start of a multi-cycle op (k), not a down-counter.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_n      = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle, predict the outputs, then compare them mid-cycle.
    task automatic step(input bit r, input bit id, input bit ex, input bit st,
                        input logic [CNT_W-1:0] n, input bit ev,
                        input logic [31:0] et, input logic [31:0] epc);
        exp_t e;
        exp_t got;
        bit   hold;
        @(posedge clk);
        #1;
        rst = r; stallreq_id = id; stallreq_ex = ex; mc_start = st;
        mc_cycles = n; exc_valid = ev; exc_type = et; cp0_epc = epc;

        e    = '0;
        hold = 1'b0;
        if (r) begin
            m_active = 1'b0;
        end else if (ev) begin
            e.flush  = 1'b1;
            e.new_pc = (et == 32'h0000_000e) ? epc : 32'h0000_0020;
            e.busy   = m_active;
            m_active = 1'b0;
        end else begin
            if (m_active) begin
                e.busy = 1'b1;
                if (m_k < m_n) begin
                    hold = 1'b1;
                    m_k++;
                end else begin
                    e.done   = 1'b1;
                    m_active = 1'b0;
                end
            end else if (st) begin
                hold     = 1'b1;
                m_active = 1'b1;
                m_k      = 1;
                m_n      = (n == 0) ? 1 : int'(n);
            end
            if (hold || ex) e.stall = 6'b001111;
            else if (id)    e.stall = 6'b000111;
        end
        sb.push_back(e);

        @(negedge clk);
        got = sb.pop_front();
        check("stall",   {26'h0, stall},   {26'h0, got.stall});
        check("flush",   {31'h0, flush},   {31'h0, got.flush});
        check("new_pc",  new_pc,           got.new_pc);
        check("mc_busy", {31'h0, mc_busy}, {31'h0, got.busy});
        check("mc_done", {31'h0, mc_done}, {31'h0, got.done});
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; mc_start = 0;
        mc_cycles = 0; exc_valid = 0; exc_type = 0; cp0_epc = 0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 6'd3, 1, 32'h0c, 32'h1234);
        idle(1);

        // Single hazard requests, and both together.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);

        // Multi-cycle op, N=4. ID requests during the op are absorbed.
        step(0, 0, 0, 1, 6'd4, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(5);

        // N=0 runs as a single-cycle hold.
        step(0, 0, 0, 1, 6'd0, 0, 0, 0);
        idle(2);

        // Exception and eret redirects.
        step(0, 1, 1, 0, 0, 1, 32'h0000_000c, 32'h8000_0100);
        step(0, 0, 0, 0, 0, 1, 32'h0000_000e, 32'h8000_0100);
        idle(1);

        // Exception in the second cycle of an N=5 op.
        step(0, 0, 0, 1, 6'd5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h0000_0008, 0);
        idle(6);

        // Exception coincident with a start from idle.
        step(0, 0, 0, 1, 6'd3, 1, 32'h0000_000a, 0);
        idle(2);

        // Reset in the third cycle of an N=6 op.
        step(0, 0, 0, 1, 6'd6, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Constrained random traffic. mc_start is only raised while idle.
        for (int i = 0; i < 400; i++) begin
            bit r, id, ex, st, ev;
            logic [31:0] et;
            r  = ($urandom_range(0, 49) == 0);
            id = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 5) == 0);
            st = !m_active && ($urandom_range(0, 4) == 0);
            ev = ($urandom_range(0, 19) == 0);
            et = ($urandom_range(0, 1) == 0) ? 32'h0000_000e : 32'h0000_000c;
            step(r, id, ex, st, CNT_W'($urandom_range(0, 9)), ev, et, $urandom);
        end
        idle(12);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
